// File: rtl/fp_stream_pkg.sv
// rtl/fp_stream_pkg.sv - shared constants and result entry type for the fp add/sub stream front-end
package fp_stream_pkg;
  localparam int FP_W      = 32;
  localparam int SIGN_BIT  = 31;
  localparam int DEF_TAG_W = 4;

  typedef struct packed {
    logic [FP_W-1:0]      q;
    logic [DEF_TAG_W-1:0] tag;
  } result_t;
endpackage

// File: rtl/fp_stream_fifo.sv
// rtl/fp_stream_fifo.sv - first-word-fall-through FIFO, power-of-2 depth, async active-low reset
module fp_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_rd;

  assign empty   = (cnt_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared too so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/fp_add_sub_stream.sv
// rtl/fp_add_sub_stream.sv - valid/ready wrapper around the fixed-latency fp_add_sub core with credit-sized output FIFO
module fp_add_sub_stream
  import fp_stream_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             core_areset,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  input  logic [31:0]      core_q
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  // One extra stage covers the core's own sampling of core_a/core_b one edge after accept.
  localparam int DL    = LATENCY + 1;
  localparam int EW    = FP_W + TAG_W;

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [FP_W-1:0]  core_a_q, core_a_d;
  logic [FP_W-1:0]  core_b_q, core_b_d;
  logic [DL-1:0]    dl_vld_q, dl_vld_d;
  logic [TAG_W-1:0] dl_tag_q [DL];
  logic [TAG_W-1:0] dl_tag_d [DL];
  logic             accept, pop, fifo_empty, fifo_wr;
  logic [EW-1:0]    fifo_wdata, fifo_rdata;

  assign core_areset = !rst_sync_q[1];
  assign in_ready    = !core_areset && (occ_q < OCC_W'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign busy        = (occ_q != '0);
  assign core_a      = core_a_q;
  assign core_b      = core_b_q;
  assign fifo_wr     = dl_vld_q[DL-1];
  assign fifo_wdata  = {core_q, dl_tag_q[DL-1]};
  assign out_q       = fifo_rdata[EW-1:TAG_W];
  assign out_tag     = fifo_rdata[TAG_W-1:0];

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    core_a_d   = core_a_q;
    core_b_d   = core_b_q;
    if (accept) begin
      core_a_d = in_a;
      core_b_d = {in_b[SIGN_BIT] ^ in_op, in_b[SIGN_BIT-1:0]};
    end
    dl_vld_d    = {dl_vld_q[DL-2:0], accept};
    dl_tag_d[0] = in_tag;
    for (int i = 1; i < DL; i++) begin
      dl_tag_d[i] = dl_tag_q[i-1];
    end
    case ({accept, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rst_sync_q <= '0;
      occ_q      <= '0;
      core_a_q   <= '0;
      core_b_q   <= '0;
      dl_vld_q   <= '0;
      for (int i = 0; i < DL; i++) begin
        dl_tag_q[i] <= '0;
      end
    end else begin
      rst_sync_q <= rst_sync_d;
      occ_q      <= occ_d;
      core_a_q   <= core_a_d;
      core_b_q   <= core_b_d;
      dl_vld_q   <= dl_vld_d;
      dl_tag_q   <= dl_tag_d;
    end
  end

  fp_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (areset_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_fp_add_sub_stream.sv
// tb/tb_fp_add_sub_stream.sv - directed self-checking bench for fp_add_sub_stream with a behavioural 3-stage core
module tb_fp_add_sub_stream;
  localparam int LAT = 3;

  logic        clk;
  logic        areset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [3:0]  out_tag;
  logic        busy;
  logic        core_areset;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [31:0] core_q;

  int n_cmp = 0;
  int n_err = 0;

  fp_add_sub_stream #(.LATENCY(LAT), .FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_tag(out_tag),
    .busy(busy), .core_areset(core_areset), .core_a(core_a), .core_b(core_b),
    .core_q(core_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic        s;
    int          e;
    real         m;
    logic [22:0] man;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    man = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, e[7:0], man};
  endfunction

  // Core model: samples core_a/core_b each edge, result visible LAT edges later; never cleared, so stale data stays around.
  logic [31:0] core_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) core_pipe[i] = 32'h4049_0FDB;
  always @(posedge clk) begin
    core_pipe[0] <= r2f(f2r(core_a) + f2r(core_b));
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_q = core_pipe[LAT-1];

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [3:0] tag, output bit ok);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp_q, input logic [3:0] exp_tag,
                             input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    n_cmp++;
    if (exp_lat >= 0 && lat !== exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end else if (!out_valid) begin
      n_err++; $display("FAIL %s timeout: no out_valid", name);
    end
    n_cmp++;
    if (out_q !== exp_q || out_tag !== exp_tag) begin
      n_err++; $display("FAIL %s result: got %h/%0d want %h/%0d", name, out_q, out_tag, exp_q, exp_tag);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    areset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, core_areset} !== 4'b0001 || out_q !== 32'h0 || out_tag !== 4'h0 ||
        core_a !== 32'h0 || core_b !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs: rdy=%b ov=%b busy=%b car=%b q=%h tag=%h a=%h b=%h want 0,0,0,1,0...",
                        in_ready, out_valid, busy, core_areset, out_q, out_tag, core_a, core_b);
    end
    areset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (core_areset !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_edge1: core_areset=%b in_ready=%b want 1,0", core_areset, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (core_areset !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_edge2: core_areset=%b in_ready=%b want 0,1", core_areset, in_ready);
    end
  endtask

  task automatic test_single_add();
    bit ok;
    out_ready = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd1, ok);
    in_valid = 1'b0;
    n_cmp++;
    if (!ok || busy !== 1'b1 || core_b !== 32'h4000_0000) begin
      n_err++; $display("FAIL add_accept: ok=%b busy=%b core_b=%h want 1,1,40000000", ok, busy, core_b);
    end
    wait_result("add", 32'h4040_0000, 4'd1, 4);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL add_drain: out_valid=%b busy=%b want 0,0", out_valid, busy);
    end
  endtask

  task automatic test_subtract();
    bit ok;
    out_ready = 1'b1;
    send(32'h40B0_0000, 32'h4050_0000, 1'b1, 4'd2, ok);
    in_valid = 1'b0;
    n_cmp++;
    if (!ok || core_b !== 32'hC050_0000 || core_a !== 32'h40B0_0000) begin
      n_err++; $display("FAIL sub_core_b: ok=%b a=%h b=%h want 40b00000,c0500000", ok, core_a, core_b);
    end
    wait_result("sub", 32'h4010_0000, 4'd2, 4);
    send(32'hC000_0000, 32'h4040_0000, 1'b0, 4'd3, ok);
    in_valid = 1'b0;
    n_cmp++;
    if (!ok || core_b !== 32'h4040_0000) begin
      n_err++; $display("FAIL negadd_core_b: ok=%b b=%h want 40400000", ok, core_b);
    end
    wait_result("negadd", 32'h3F80_0000, 4'd3, 4);
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [5] = '{32'h4120_0000, 32'h0000_0000, 32'h3F80_0000, 32'h40B0_0000, 32'hC000_0000};
    logic [31:0] vb [5] = '{32'h41A0_0000, 32'h0000_0000, 32'h4000_0000, 32'h4050_0000, 32'h4040_0000};
    logic [31:0] vq [5] = '{32'h41F0_0000, 32'h0000_0000, 32'h4040_0000, 32'h410C_0000, 32'h3F80_0000};
    int cyc [5];
    int got;
    wait_idle();
    out_ready = 1'b1;
    got = 0;
    fork
      begin
        bit ok;
        for (int i = 0; i < 5; i++) begin
          send(va[i], vb[i], 1'b0, 4'(5 + i), ok);
          n_cmp++;
          if (!ok) begin n_err++; $display("FAIL b2b_accept%0d: timeout", i); end
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 80 && got < 5; c++) begin
          @(negedge clk);
          if (out_valid) begin
            n_cmp++;
            if (out_q !== vq[got] || out_tag !== 4'(5 + got)) begin
              n_err++; $display("FAIL b2b_result%0d: got %h/%0d want %h/%0d", got, out_q, out_tag, vq[got], 5 + got);
            end
            cyc[got] = c;
            got++;
          end
        end
      end
    join
    n_cmp++;
    if (got !== 5) begin n_err++; $display("FAIL b2b_count: got %0d want 5", got); end
    else begin
      n_cmp++;
      if (cyc[1] - cyc[0] != 1 || cyc[2] - cyc[1] != 1 || cyc[3] - cyc[2] != 1) begin
        n_err++; $display("FAIL b2b_spacing: cycles %0d %0d %0d %0d want consecutive", cyc[0], cyc[1], cyc[2], cyc[3]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] va [5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4120_0000};
    logic [31:0] vb [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h41A0_0000};
    logic        vo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] vq [5] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h4000_0000, 32'h41F0_0000};
    int idx;
    int got;
    wait_idle();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx]; in_op = vo[idx]; in_tag = 4'(10 + idx);
      if (in_ready && idx < 4) idx++;
      else if (in_ready) begin idx = 9; end
      @(negedge clk);
    end
    n_cmp++;
    if (idx !== 4 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_accepted: count=%0d in_ready=%b want 4,0", idx, in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_q !== vq[0] || out_tag !== 4'd10) begin
      n_err++; $display("FAIL bp_head: ov=%b q=%h tag=%0d want 1,%h,10", out_valid, out_q, out_tag, vq[0]);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_q !== vq[0] || out_tag !== 4'd10) begin
      n_err++; $display("FAIL bp_hold: ov=%b q=%h tag=%0d want 1,%h,10", out_valid, out_q, out_tag, vq[0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_q !== vq[1] || out_tag !== 4'd11) begin
      n_err++; $display("FAIL bp_pop: in_ready=%b q=%h tag=%0d want 1,%h,11", in_ready, out_q, out_tag, vq[1]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL bp_fifth: in_ready=%b busy=%b want 0,1", in_ready, busy);
    end
    out_ready = 1'b1;
    got = 1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (out_valid) begin
        n_cmp++;
        if (out_q !== vq[got] || out_tag !== 4'(10 + got)) begin
          n_err++; $display("FAIL bp_drain%0d: got %h/%0d want %h/%0d", got, out_q, out_tag, vq[got], 10 + got);
        end
        got++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got !== 5) begin n_err++; $display("FAIL bp_drain_count: got %0d want 5", got); end
  endtask

  task automatic test_midflight_reset();
    bit ok;
    bit seen;
    wait_idle();
    out_ready = 1'b1;
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd4, ok);
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 4'd5, ok);
    in_valid = 1'b0;
    @(negedge clk);
    areset_n = 1'b0;
    #1;
    n_cmp++;
    if (core_areset !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_async: core_areset=%b busy=%b in_ready=%b want 1,0,0", core_areset, busy, in_ready);
    end
    @(negedge clk);
    areset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL mid_stale: out_valid seen=%b want 0", seen); end
    send(32'h4120_0000, 32'h41A0_0000, 1'b0, 4'd3, ok);
    in_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mid_accept: timeout"); end
    wait_result("mid_post", 32'h41F0_0000, 4'd3, 4);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_subtract();
    test_back_to_back();
    test_backpressure();
    test_midflight_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
